// File: rtl/video_timing_param.sv
// Raster timing generator. It produces a single-clock pixel strobe, sync/DE levels,
// coordinates and line/frame start pulses, all registered from the next counter state.
module video_timing_param #(
  parameter int unsigned CLK_DIV  = 4,
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned H_FP     = 16,
  parameter int unsigned H_SYNC   = 96,
  parameter int unsigned H_BP     = 48,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned V_FP     = 10,
  parameter int unsigned V_SYNC   = 2,
  parameter int unsigned V_BP     = 33,
  parameter int unsigned H_POL    = 0,
  parameter int unsigned V_POL    = 0,
  parameter int unsigned CW       = 10
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          en,
  output logic          pclk_en,
  output logic          h_sync,
  output logic          v_sync,
  output logic          DE,
  output logic [CW-1:0] x_pixel,
  output logic [CW-1:0] y_pixel,
  output logic          line_start,
  output logic          frame_start
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int unsigned DW      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  if (CLK_DIV < 1 || (64'(1) << CW) < 64'(H_TOTAL) || (64'(1) << CW) < 64'(V_TOTAL))
  begin : g_bad_cfg
    $error("video_timing_param: CLK_DIV must be >= 1 and CW must cover H/V totals");
  end

  localparam logic [DW-1:0] DivLast = DW'(CLK_DIV - 1);
  localparam logic [CW-1:0] HLast   = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] VLast   = CW'(V_TOTAL - 1);
  // One extra bit so window ends equal to 2^CW do not truncate.
  localparam logic [CW:0]   HAct    = (CW+1)'(H_ACTIVE);
  localparam logic [CW:0]   HSyncLo = (CW+1)'(H_ACTIVE + H_FP);
  localparam logic [CW:0]   HSyncHi = (CW+1)'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CW:0]   VAct    = (CW+1)'(V_ACTIVE);
  localparam logic [CW:0]   VSyncLo = (CW+1)'(V_ACTIVE + V_FP);
  localparam logic [CW:0]   VSyncHi = (CW+1)'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic          HPol    = 1'(H_POL);
  localparam logic          VPol    = 1'(V_POL);

  logic [DW-1:0] div_q, div_d;
  logic [CW-1:0] h_q, h_d, v_q, v_d;
  logic [CW:0]   h_ext, v_ext;
  logic          adv;
  logic          pclk_en_q, h_sync_q, v_sync_q, de_q, line_start_q, frame_start_q;

  always_comb begin
    // A pixel step happens on the enabled edge that wraps the divider.
    adv   = en && (div_q == DivLast);
    div_d = div_q;
    h_d   = h_q;
    v_d   = v_q;
    if (en) begin
      div_d = (div_q == DivLast) ? '0 : div_q + DW'(1);
    end
    if (adv) begin
      h_d = (h_q == HLast) ? '0 : h_q + CW'(1);
      if (h_q == HLast) begin
        v_d = (v_q == VLast) ? '0 : v_q + CW'(1);
      end
    end
    h_ext = {1'b0, h_d};
    v_ext = {1'b0, v_d};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      div_q         <= '0;
      h_q           <= HLast;
      v_q           <= VLast;
      pclk_en_q     <= 1'b0;
      h_sync_q      <= ~HPol;
      v_sync_q      <= ~VPol;
      de_q          <= 1'b0;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      div_q         <= div_d;
      h_q           <= h_d;
      v_q           <= v_d;
      pclk_en_q     <= en && (div_d == DivLast);
      h_sync_q      <= (h_ext >= HSyncLo && h_ext < HSyncHi) ? HPol : ~HPol;
      v_sync_q      <= (v_ext >= VSyncLo && v_ext < VSyncHi) ? VPol : ~VPol;
      de_q          <= (h_ext < HAct) && (v_ext < VAct);
      line_start_q  <= adv && (h_d == '0);
      frame_start_q <= adv && (h_d == '0) && (v_d == '0);
    end
  end

  assign pclk_en     = pclk_en_q;
  assign h_sync      = h_sync_q;
  assign v_sync      = v_sync_q;
  assign DE          = de_q;
  assign x_pixel     = h_q;
  assign y_pixel     = v_q;
  assign line_start  = line_start_q;
  assign frame_start = frame_start_q;

endmodule

// File: tb/tb_video_timing_param.sv
// Bench for video_timing_param: three configurations driven by shared reset/en, each
// checked every cycle against a raster model built on enabled-clock and pixel counts.
module tb_video_timing_param;

  localparam int NU = 3;
  localparam int CD [NU] = '{4, 2, 1};
  localparam int HA [NU] = '{640, 4, 640};
  localparam int HF [NU] = '{16, 1, 16};
  localparam int HS [NU] = '{96, 2, 96};
  localparam int HB [NU] = '{48, 1, 48};
  localparam int VA [NU] = '{480, 3, 3};
  localparam int VF [NU] = '{10, 1, 1};
  localparam int VS [NU] = '{2, 1, 1};
  localparam int VB [NU] = '{33, 1, 1};
  localparam int HP [NU] = '{0, 1, 0};
  localparam int VP [NU] = '{0, 0, 1};

  typedef struct {
    logic        pclk, hs, vs, de, ls, fs;
    logic [15:0] x, y;
  } obs_t;

  logic clk = 1'b0;
  logic reset, en;
  always #5 clk = ~clk;

  logic       pclk0, hs0, vs0, de0, ls0, fs0;
  logic [9:0] x0, y0;
  logic       pclk1, hs1, vs1, de1, ls1, fs1;
  logic [3:0] x1, y1;
  logic       pclk2, hs2, vs2, de2, ls2, fs2;
  logic [9:0] x2, y2;

  video_timing_param #(
    .CLK_DIV(CD[0]), .H_ACTIVE(HA[0]), .H_FP(HF[0]), .H_SYNC(HS[0]), .H_BP(HB[0]),
    .V_ACTIVE(VA[0]), .V_FP(VF[0]), .V_SYNC(VS[0]), .V_BP(VB[0]),
    .H_POL(HP[0]), .V_POL(VP[0]), .CW(10)
  ) u_dut0 (
    .clk(clk), .reset(reset), .en(en), .pclk_en(pclk0), .h_sync(hs0), .v_sync(vs0),
    .DE(de0), .x_pixel(x0), .y_pixel(y0), .line_start(ls0), .frame_start(fs0)
  );

  video_timing_param #(
    .CLK_DIV(CD[1]), .H_ACTIVE(HA[1]), .H_FP(HF[1]), .H_SYNC(HS[1]), .H_BP(HB[1]),
    .V_ACTIVE(VA[1]), .V_FP(VF[1]), .V_SYNC(VS[1]), .V_BP(VB[1]),
    .H_POL(HP[1]), .V_POL(VP[1]), .CW(4)
  ) u_dut1 (
    .clk(clk), .reset(reset), .en(en), .pclk_en(pclk1), .h_sync(hs1), .v_sync(vs1),
    .DE(de1), .x_pixel(x1), .y_pixel(y1), .line_start(ls1), .frame_start(fs1)
  );

  video_timing_param #(
    .CLK_DIV(CD[2]), .H_ACTIVE(HA[2]), .H_FP(HF[2]), .H_SYNC(HS[2]), .H_BP(HB[2]),
    .V_ACTIVE(VA[2]), .V_FP(VF[2]), .V_SYNC(VS[2]), .V_BP(VB[2]),
    .H_POL(HP[2]), .V_POL(VP[2]), .CW(10)
  ) u_dut2 (
    .clk(clk), .reset(reset), .en(en), .pclk_en(pclk2), .h_sync(hs2), .v_sync(vs2),
    .DE(de2), .x_pixel(x2), .y_pixel(y2), .line_start(ls2), .frame_start(fs2)
  );

  int   n_compared   = 0;
  int   n_mismatched = 0;
  int   en_cnt [NU];
  int   pix    [NU];
  obs_t sb_q   [NU][$];

  function automatic obs_t dut_obs(input int u);
    obs_t o;
    case (u)
      0: begin
        o.pclk = pclk0; o.hs = hs0; o.vs = vs0; o.de = de0; o.ls = ls0; o.fs = fs0;
        o.x = 16'(x0); o.y = 16'(y0);
      end
      1: begin
        o.pclk = pclk1; o.hs = hs1; o.vs = vs1; o.de = de1; o.ls = ls1; o.fs = fs1;
        o.x = 16'(x1); o.y = 16'(y1);
      end
      default: begin
        o.pclk = pclk2; o.hs = hs2; o.vs = vs2; o.de = de2; o.ls = ls2; o.fs = fs2;
        o.x = 16'(x2); o.y = 16'(y2);
      end
    endcase
    return o;
  endfunction

  // Level outputs follow directly from the linear pixel index within the frame.
  function automatic obs_t levels(input int u, input int id);
    obs_t o;
    int   ht, x, y;
    logic hp, vp;
    ht = HA[u] + HF[u] + HS[u] + HB[u];
    x  = id % ht;
    y  = id / ht;
    hp = (HP[u] != 0);
    vp = (VP[u] != 0);
    o.x    = 16'(x);
    o.y    = 16'(y);
    o.de   = (x < HA[u]) && (y < VA[u]);
    o.hs   = (x >= HA[u] + HF[u] && x < HA[u] + HF[u] + HS[u]) ? hp : ~hp;
    o.vs   = (y >= VA[u] + VF[u] && y < VA[u] + VF[u] + VS[u]) ? vp : ~vp;
    o.pclk = 1'b0;
    o.ls   = 1'b0;
    o.fs   = 1'b0;
    return o;
  endfunction

  task automatic model_step(input logic r, input logic e);
    for (int u = 0; u < NU; u++) begin
      obs_t o;
      int   fsz;
      logic adv;
      fsz = (HA[u] + HF[u] + HS[u] + HB[u]) * (VA[u] + VF[u] + VS[u] + VB[u]);
      if (r) begin
        en_cnt[u] = 0;
        pix[u]    = fsz - 1;
        o         = levels(u, pix[u]);
        o.de      = 1'b0;
        o.hs      = (HP[u] == 0);
        o.vs      = (VP[u] == 0);
      end else if (e) begin
        en_cnt[u] = en_cnt[u] + 1;
        adv       = (en_cnt[u] % CD[u]) == 0;
        if (adv) pix[u] = (pix[u] + 1) % fsz;
        o      = levels(u, pix[u]);
        o.pclk = (en_cnt[u] % CD[u]) == CD[u] - 1;
        o.ls   = adv && (o.x == 16'd0);
        o.fs   = adv && (pix[u] == 0);
      end else begin
        o = levels(u, pix[u]);
      end
      sb_q[u].push_back(o);
    end
  endtask

  task automatic step(input logic r, input logic e);
    reset = r;
    en    = e;
    model_step(r, e);
    @(posedge clk);
    #2;
  endtask

  initial begin : monitor
    int cyc;
    cyc = 0;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      for (int u = 0; u < NU; u++) begin
        if (sb_q[u].size() != 0) begin
          obs_t ex, got;
          ex  = sb_q[u].pop_front();
          got = dut_obs(u);
          n_compared++;
          if (got.pclk !== ex.pclk || got.hs !== ex.hs || got.vs !== ex.vs ||
              got.de !== ex.de || got.ls !== ex.ls || got.fs !== ex.fs ||
              got.x !== ex.x || got.y !== ex.y) begin
            n_mismatched++;
            if (n_mismatched <= 20)
              $display("FAIL unit%0d cycle %0d: got pclk=%b hs=%b vs=%b de=%b ls=%b fs=%b x=%0d y=%0d, required pclk=%b hs=%b vs=%b de=%b ls=%b fs=%b x=%0d y=%0d",
                       u, cyc, got.pclk, got.hs, got.vs, got.de, got.ls, got.fs, got.x, got.y,
                       ex.pclk, ex.hs, ex.vs, ex.de, ex.ls, ex.fs, ex.x, ex.y);
          end
        end
      end
    end
  end

  initial begin : stimulus
    reset = 1'b1;
    en    = 1'b0;
    step(1'b1, 1'b0);
    step(1'b1, 1'b1);
    // Free run past x=100 on the default config, then a 7-cycle stall.
    repeat (405) step(1'b0, 1'b1);
    repeat (7) step(1'b0, 1'b0);
    repeat (3000) step(1'b0, 1'b1);
    repeat (4000) step(1'b0, $urandom_range(0, 3) != 0);
    // Reset mid-frame with en both high and low around it.
    step(1'b1, 1'b0);
    repeat (1500) step(1'b0, 1'b1);
    step(1'b1, 1'b1);
    repeat (2000) step(1'b0, $urandom_range(0, 1) != 0);
    repeat (1000) step(1'b0, 1'b1);
    @(posedge clk);
    #3;
    for (int u = 0; u < NU; u++) begin
      n_compared++;
      if (sb_q[u].size() != 0) begin
        n_mismatched++;
        $display("FAIL unit%0d drain: got %0d pending entries, required 0", u, sb_q[u].size());
      end
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule

// File: doc/video_timing_param.md
# video_timing_param

Parametrised raster timing generator: the next generation of the display timing block, with resolution, porches, sync polarity and pixel-rate divider all set by parameters. It produces a single-cycle pixel-enable strobe instead of a derived clock, so the whole display path stays on one clock. It feeds h/v sync, data-enable, pixel coordinates and line/frame start strobes to the pixel generators and the video output stage. Counting can be paused with a run enable.

## Interface
- CLK_DIV, 4: system clocks per pixel, ≥1.
- H_ACTIVE, 640: visible pixels per line.
- H_FP, 16: horizontal front porch, in pixels.
- H_SYNC, 96: horizontal sync width, in pixels.
- H_BP, 48: horizontal back porch, in pixels.
- V_ACTIVE, 480: visible lines per frame.
- V_FP, 10: vertical front porch, in lines.
- V_SYNC, 2: vertical sync width, in lines.
- V_BP, 33: vertical back porch, in lines.
- H_POL, 0: asserted level of h_sync (0 = active-low).
- V_POL, 0: asserted level of v_sync.
- CW, 10: coordinate width. Elaboration fails unless 2^CW ≥ max(H_TOTAL, V_TOTAL).

Ports:
- clk  in  1  system clock; the single clock of the block.
- reset  in  1  synchronous, active-high reset.
- en  in  1  run enable; low freezes the divider and counters.
- pclk_en  out  1  one-clk pixel strobe.
- h_sync  out  1  horizontal sync, level set by H_POL.
- v_sync  out  1  vertical sync, level set by V_POL.
- DE  out  1  high in the active area.
- x_pixel  out  CW  horizontal counter value.
- y_pixel  out  CW  vertical counter value.
- line_start  out  1  one-clk pulse when the line counter wraps to 0.
- frame_start  out  1  one-clk pulse when the frame wraps to (0,0).

## Operation
- Derived totals: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (default 800); V_TOTAL likewise (default 525).
- Divider counter div runs 0..CLK_DIV-1 and advances only when en=1.
- pclk_en is registered. It is high for the one clk cycle after div reaches CLK_DIV-1 with en=1.
- CLK_DIV=1: pclk_en follows en delayed by one cycle, i.e. high every cycle while en stays high.
- Horizontal counter h: on each clk edge where pclk_en=1, h ← (h = H_TOTAL-1) ? 0 : h+1.
- Vertical counter v: advances only when h wraps; v ← (v = V_TOTAL-1) ? 0 : v+1.
- All outputs are registered decodes of the next counter state, so outputs always match the counters and never lag them.
  - x_pixel = h; y_pixel = v (raw values, including the blanking region).
  - DE = (h < H_ACTIVE) && (v < V_ACTIVE).
  - h_sync = H_POL when H_ACTIVE+H_FP ≤ h < H_ACTIVE+H_FP+H_SYNC, else ~H_POL.
  - v_sync = V_POL when V_ACTIVE+V_FP ≤ v < V_ACTIVE+V_FP+V_SYNC, else ~V_POL. v_sync changes only together with a line wrap.
  - line_start = 1 for the single clk cycle in which the outputs first show h=0.
  - frame_start = 1 for the single clk cycle in which the outputs first show h=0, v=0. frame_start implies line_start.
- en=0:
  - div, h and v hold.
  - pclk_en, line_start and frame_start drop to 0 on the next edge.
  - The level outputs (sync, DE, x, y) hold their values.
- Reset:
  - div=0, h=H_TOTAL-1, v=V_TOTAL-1.
  - Outputs: x_pixel=H_TOTAL-1, y_pixel=V_TOTAL-1, DE=0, h_sync=~H_POL, v_sync=~V_POL, pclk_en=0, line_start=0, frame_start=0.
  - Because of this reset position, the first pixel advance wraps to (0,0) and produces frame_start.
- Reset asserted mid-frame takes effect on the next edge regardless of en or div. No partial line or frame is completed.

## Timing
- Reset released at edge 0, with en held high:
  - pclk_en is high in cycle CLK_DIV-1 (after edge CLK_DIV-1).
  - At edge CLK_DIV, x=0, y=0, DE=1, and line_start=frame_start=1 for that one cycle.
- Counters step once per CLK_DIV clocks. Each coordinate is stable for exactly CLK_DIV cycles.
- Line period is H_TOTAL·CLK_DIV clocks; frame period is H_TOTAL·V_TOTAL·CLK_DIV clocks (default 1,680,000).
- Sync edges, DE edges and x/y changes occur only on the edge ending a pclk_en cycle, never in between.
- An en low of N cycles stretches the current pixel by exactly N cycles. The div phase is preserved across the stall.

## Test plan
- Default parameters, en=1, run 2 frames:
  - frame_start period 1,680,000 clk; line_start period 3,200 clk.
  - DE high for 640 pixels × 480 lines; h_sync low for h in 656..751; v_sync low for lines 490..491.
- Small config (H 4/1/2/1, V 3/1/1/1, CLK_DIV=2):
  - Exact sequence per pixel step: x = 0,1,2,3,4,5,6,7,0.
  - h_sync asserted at x=5,6; DE at x=0..3 with y<3; v_sync asserted at y=4.
- H_POL=1, V_POL=0: h_sync is high only in the sync window; v_sync stays active-low. Reset values are h_sync=0, v_sync=1.
- en low for 7 cycles mid-line at x=100 (default config): x stays 100 for 4+7 clk, then resumes at 101. No pulses occur during the stall.
- Reset asserted at x=300, y=200:
  - Next edge shows x=799, y=524, DE=0, syncs inactive.
  - After release, frame_start fires CLK_DIV cycles later.
- CLK_DIV=1: pclk_en stays high continuously; x increments every clk; line_start period is 800 clk.
